// File: rtl/fight_pkg.sv
// Shared fight-engine definitions: attack phase encodings and the renderer
// colours associated with each phase.
package fight_pkg;

    typedef enum logic [1:0] {
        PH_IDLE     = 2'b00,
        PH_STARTUP  = 2'b01,
        PH_ACTIVE   = 2'b10,
        PH_RECOVERY = 2'b11
    } phase_e;

    // 12-bit RGB tint the renderer applies to a character in each phase
    localparam logic [11:0] COL_IDLE     = 12'h888;
    localparam logic [11:0] COL_STARTUP  = 12'hFF0;
    localparam logic [11:0] COL_ACTIVE   = 12'hF00;
    localparam logic [11:0] COL_RECOVERY = 12'h00F;

    function automatic logic [11:0] phase_colour(input phase_e ph);
        logic [11:0] col;
        case (ph)
            PH_STARTUP:  col = COL_STARTUP;
            PH_ACTIVE:   col = COL_ACTIVE;
            PH_RECOVERY: col = COL_RECOVERY;
            default:     col = COL_IDLE;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/attack_sequencer_if.sv
// Per-player attack control bus: frame/enable/button/hit inputs toward the
// sequencer, phase and hit-confirm outputs toward renderer and collision logic.
interface attack_sequencer_if;

    logic       frame_tick;
    logic       enable;
    logic       attack_btn;
    logic       hit_in;
    logic [1:0] attack_phase;
    logic       attack_busy;
    logic       hit_ack;
    logic [7:0] frames_left;

    modport master (
        output frame_tick,
        output enable,
        output attack_btn,
        output hit_in,
        input  attack_phase,
        input  attack_busy,
        input  hit_ack,
        input  frames_left
    );

    modport slave (
        input  frame_tick,
        input  enable,
        input  attack_btn,
        input  hit_in,
        output attack_phase,
        output attack_busy,
        output hit_ack,
        output frames_left
    );

endinterface

// File: rtl/attack_sequencer.sv
// Frame-based attack state machine: IDLE -> STARTUP -> ACTIVE -> RECOVERY,
// with press edge detection, a one-deep late-recovery buffer and single hit confirm.
module attack_sequencer
    import fight_pkg::*;
#(
    parameter int STARTUP_FRAMES  = 5,
    parameter int ACTIVE_FRAMES   = 2,
    parameter int RECOVERY_FRAMES = 16,
    parameter int BUFFER_FRAMES   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    attack_sequencer_if.slave bus
);

    localparam logic [7:0] STARTUP_LOAD  = 8'(STARTUP_FRAMES - 1);
    localparam logic [7:0] ACTIVE_LOAD   = 8'(ACTIVE_FRAMES - 1);
    localparam logic [7:0] RECOVERY_LOAD = 8'(RECOVERY_FRAMES - 1);
    localparam logic [7:0] BUFFER_LIMIT  = 8'(BUFFER_FRAMES);

    phase_e     phase_q, phase_d;
    logic [7:0] frames_left_q, frames_left_d;
    logic       pend_q, pend_d;
    logic       buf_q, buf_d;
    logic       hit_landed_q, hit_landed_d;
    logic       hit_ack_q, hit_ack_d;
    logic       busy_q, busy_d;
    logic       btn_q, btn_d;

    logic press;
    logic count_done;

    assign press      = bus.attack_btn & ~btn_q;
    assign count_done = (frames_left_q == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q       <= PH_IDLE;
            frames_left_q <= 8'd0;
            pend_q        <= 1'b0;
            buf_q         <= 1'b0;
            hit_landed_q  <= 1'b0;
            hit_ack_q     <= 1'b0;
            busy_q        <= 1'b0;
            btn_q         <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            frames_left_q <= frames_left_d;
            pend_q        <= pend_d;
            buf_q         <= buf_d;
            hit_landed_q  <= hit_landed_d;
            hit_ack_q     <= hit_ack_d;
            busy_q        <= busy_d;
            btn_q         <= btn_d;
        end
    end

    always_comb begin
        phase_d       = phase_q;
        frames_left_d = frames_left_q;
        pend_d        = pend_q;
        buf_d         = buf_q;
        hit_landed_d  = hit_landed_q;
        hit_ack_d     = 1'b0;
        // button history keeps tracking while disabled so a held button never fires on enable
        btn_d         = bus.attack_btn;

        if (!bus.enable) begin
            phase_d       = PH_IDLE;
            frames_left_d = 8'd0;
            pend_d        = 1'b0;
            buf_d         = 1'b0;
            hit_landed_d  = 1'b0;
        end else begin
            case (phase_q)
                PH_IDLE: begin
                    if (bus.frame_tick && (pend_q || press)) begin
                        phase_d       = PH_STARTUP;
                        frames_left_d = STARTUP_LOAD;
                        pend_d        = 1'b0;
                        hit_landed_d  = 1'b0;
                    end else if (press) begin
                        pend_d = 1'b1;
                    end
                end

                PH_STARTUP: begin
                    if (bus.frame_tick) begin
                        if (!count_done) begin
                            frames_left_d = frames_left_q - 8'd1;
                        end else begin
                            phase_d       = PH_ACTIVE;
                            frames_left_d = ACTIVE_LOAD;
                        end
                    end
                end

                PH_ACTIVE: begin
                    if (bus.hit_in && !hit_landed_q) begin
                        hit_ack_d    = 1'b1;
                        hit_landed_d = 1'b1;
                    end
                    if (bus.frame_tick) begin
                        if (!count_done) begin
                            frames_left_d = frames_left_q - 8'd1;
                        end else begin
                            phase_d       = PH_RECOVERY;
                            frames_left_d = RECOVERY_LOAD;
                        end
                    end
                end

                PH_RECOVERY: begin
                    if (press && (frames_left_q < BUFFER_LIMIT)) begin
                        buf_d = 1'b1;
                    end
                    if (bus.frame_tick) begin
                        if (!count_done) begin
                            frames_left_d = frames_left_q - 8'd1;
                        end else if (buf_q || press) begin
                            // chain straight into the next attack without an IDLE frame
                            phase_d       = PH_STARTUP;
                            frames_left_d = STARTUP_LOAD;
                            buf_d         = 1'b0;
                            hit_landed_d  = 1'b0;
                        end else begin
                            phase_d       = PH_IDLE;
                            frames_left_d = 8'd0;
                            buf_d         = 1'b0;
                        end
                    end
                end

                default: begin
                    phase_d       = PH_IDLE;
                    frames_left_d = 8'd0;
                end
            endcase
        end

        busy_d = (phase_d != PH_IDLE);
    end

    assign bus.attack_phase = phase_q;
    assign bus.attack_busy  = busy_q;
    assign bus.hit_ack      = hit_ack_q;
    assign bus.frames_left  = frames_left_q;

endmodule

// File: tb/tb_attack_sequencer.sv
// Directed bench for attack_sequencer: a vector table for the first attack,
// then hand-written sequences for buffering, hit confirm, cancel and reset.
module tb_attack_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    attack_sequencer_if bus ();

    attack_sequencer #(
        .STARTUP_FRAMES (5),
        .ACTIVE_FRAMES  (2),
        .RECOVERY_FRAMES(16),
        .BUFFER_FRAMES  (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       tick;
        logic       en;
        logic       btn;
        logic       hit;
        logic [1:0] ph;
        logic [7:0] fl;
        logic       busy;
        logic       ack;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic t, input logic e, input logic b, input logic h,
                                input logic [1:0] ph, input logic [7:0] fl,
                                input logic busy, input logic ack);
        vec_t v;
        v.tick = t; v.en = e; v.btn = b; v.hit = h;
        v.ph = ph; v.fl = fl; v.busy = busy; v.ack = ack;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] ph, input logic [7:0] fl,
                           input logic busy, input logic ack);
        $display("[%0t] %s: phase=%0d frames_left=%0d busy=%0d hit_ack=%0d", $time, tag,
                 bus.attack_phase, bus.frames_left, bus.attack_busy, bus.hit_ack);
        chk({tag, ".phase"},       32'(bus.attack_phase), 32'(ph));
        chk({tag, ".frames_left"}, 32'(bus.frames_left),  32'(fl));
        chk({tag, ".busy"},        32'(bus.attack_busy),  32'(busy));
        chk({tag, ".hit_ack"},     32'(bus.hit_ack),      32'(ack));
    endtask

    // one clock cycle: inputs set at the falling edge, outputs sampled 1 after the rising edge
    task automatic cyc(input logic t, input logic e, input logic b, input logic h);
        @(negedge clk);
        bus.frame_tick = t;
        bus.enable     = e;
        bus.attack_btn = b;
        bus.hit_in     = h;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n, input logic b);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, b, 1'b0);
    endtask

    initial begin
        int k;
        int nbusy;
        logic [1:0] eph;
        logic [7:0] efl;

        bus.frame_tick = 1'b0;
        bus.enable     = 1'b1;
        bus.attack_btn = 1'b0;
        bus.hit_in     = 1'b0;

        vecs[0]  = mk(0, 1, 0, 0, 2'd0, 8'd0,  0, 0);
        vecs[1]  = mk(0, 1, 1, 0, 2'd0, 8'd0,  0, 0);
        vecs[2]  = mk(1, 1, 1, 0, 2'd1, 8'd4,  1, 0);
        vecs[3]  = mk(1, 1, 0, 0, 2'd1, 8'd3,  1, 0);
        vecs[4]  = mk(1, 1, 0, 0, 2'd1, 8'd2,  1, 0);
        vecs[5]  = mk(1, 1, 0, 0, 2'd1, 8'd1,  1, 0);
        vecs[6]  = mk(1, 1, 0, 0, 2'd1, 8'd0,  1, 0);
        vecs[7]  = mk(1, 1, 0, 0, 2'd2, 8'd1,  1, 0);
        vecs[8]  = mk(0, 1, 0, 1, 2'd2, 8'd1,  1, 1);
        vecs[9]  = mk(0, 1, 0, 1, 2'd2, 8'd1,  1, 0);
        vecs[10] = mk(1, 1, 0, 0, 2'd2, 8'd0,  1, 0);
        vecs[11] = mk(1, 1, 0, 0, 2'd3, 8'd15, 1, 0);
        vecs[12] = mk(0, 1, 0, 1, 2'd3, 8'd15, 1, 0);
        vecs[13] = mk(1, 1, 0, 0, 2'd3, 8'd14, 1, 0);

        repeat (3) @(posedge clk);
        #1;
        chk_out("reset", 2'd0, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // first attack from the table: pend via press, two hits in ACTIVE, one ack
        for (int i = 0; i < 14; i++) begin
            cyc(vecs[i].tick, vecs[i].en, vecs[i].btn, vecs[i].hit);
            chk_out($sformatf("vec%0d", i), vecs[i].ph, vecs[i].fl, vecs[i].busy, vecs[i].ack);
        end
        ticks(14, 1'b0);
        chk_out("rec_last", 2'd3, 8'd0, 1'b1, 1'b0);
        cyc(1, 1, 0, 0);
        chk_out("back_idle", 2'd0, 8'd0, 1'b0, 1'b0);

        // press coinciding with a tick, then discarded presses in STARTUP and early RECOVERY
        cyc(1, 1, 1, 0);
        chk_out("press_with_tick", 2'd1, 8'd4, 1'b1, 1'b0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 0, 0);
        chk_out("press_in_startup", 2'd1, 8'd4, 1'b1, 1'b0);
        ticks(4, 1'b0);
        ticks(1, 1'b0);
        chk_out("enter_active", 2'd2, 8'd1, 1'b1, 1'b0);
        ticks(2, 1'b0);
        ticks(5, 1'b0);
        chk_out("rec10", 2'd3, 8'd10, 1'b1, 1'b0);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 0, 0);
        ticks(10, 1'b0);
        chk_out("rec0_unbuffered", 2'd3, 8'd0, 1'b1, 1'b0);
        cyc(1, 1, 0, 0);
        chk_out("early_press_dropped", 2'd0, 8'd0, 1'b0, 1'b0);
        cyc(1, 1, 0, 0);
        chk_out("no_stale_press", 2'd0, 8'd0, 1'b0, 1'b0);

        // hit filtering by phase, then a buffered press chaining into the next attack
        cyc(1, 1, 1, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 1);
        chk_out("hit_in_startup", 2'd1, 8'd4, 1'b1, 1'b0);
        cyc(0, 1, 0, 0);
        chk_out("hit_in_startup2", 2'd1, 8'd4, 1'b1, 1'b0);
        ticks(5, 1'b0);
        cyc(0, 1, 0, 1);
        chk_out("hit_first", 2'd2, 8'd1, 1'b1, 1'b1);
        cyc(0, 1, 0, 1);
        chk_out("hit_second", 2'd2, 8'd1, 1'b1, 1'b0);
        ticks(2, 1'b0);
        cyc(0, 1, 0, 1);
        chk_out("hit_in_recovery", 2'd3, 8'd15, 1'b1, 1'b0);
        ticks(13, 1'b0);
        chk_out("rec2", 2'd3, 8'd2, 1'b1, 1'b0);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 0, 0);
        ticks(2, 1'b0);
        chk_out("rec0_buffered", 2'd3, 8'd0, 1'b1, 1'b0);
        cyc(1, 1, 0, 0);
        chk_out("buffered_restart", 2'd1, 8'd4, 1'b1, 1'b0);
        ticks(5, 1'b0);
        cyc(0, 1, 0, 1);
        chk_out("hit_next_attack", 2'd2, 8'd1, 1'b1, 1'b1);

        // cancel with enable low while the button is held
        cyc(0, 1, 1, 0);
        chk_out("held_in_active", 2'd2, 8'd1, 1'b1, 1'b0);
        cyc(0, 0, 1, 1);
        chk_out("enable_drop", 2'd0, 8'd0, 1'b0, 1'b0);
        cyc(1, 0, 1, 0);
        chk_out("disabled_tick", 2'd0, 8'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 1, 0);
            chk_out($sformatf("reenable_held%0d", i), 2'd0, 8'd0, 1'b0, 1'b0);
        end
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        chk_out("repress_pend", 2'd0, 8'd0, 1'b0, 1'b0);
        cyc(1, 1, 1, 0);
        chk_out("repress", 2'd1, 8'd4, 1'b1, 1'b0);

        // asynchronous reset in the middle of RECOVERY, between clock edges
        ticks(4, 1'b0);
        ticks(3, 1'b0);
        ticks(3, 1'b0);
        chk_out("rec12", 2'd3, 8'd12, 1'b1, 1'b0);
        @(negedge clk);
        bus.frame_tick = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_reset", 2'd0, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // after reset: press at cycle 3, a frame tick every 10 cycles
        k = 0;
        nbusy = 0;
        for (int c = 0; c < 250; c++) begin
            cyc((c % 10) == 9, 1'b1, (c == 3) || (c == 4), 1'b0);
            if ((c % 10) == 9) begin
                if (k < 5) begin
                    eph = 2'd1; efl = 8'(4 - k);
                end else if (k < 7) begin
                    eph = 2'd2; efl = 8'(6 - k);
                end else if (k < 23) begin
                    eph = 2'd3; efl = 8'(22 - k);
                end else begin
                    eph = 2'd0; efl = 8'd0;
                end
                chk_out($sformatf("frame%0d", k), eph, efl, eph != 2'd0, 1'b0);
                if (bus.attack_busy) nbusy++;
                k++;
            end
        end
        chk("busy_tick_count", 32'(nbusy), 32'd23);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
